// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
//  Module      : csr_trap_unit
//  Description : Machine-mode CSR file and trap sequencer. Holds the M-mode
//                CSRs plus 64-bit mcycle/minstret, arbitrates interrupt,
//                exception, illegal-CSR, mret and CSR-write events for the
//                instruction completing in execute, and produces the PC
//                redirect for trap entry (mtvec) and mret (mepc).
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                instr_valid, pc    - completing instruction and its PC
//                csr_op/addr/wdata  - CSR access request (0 none,1 w,2 s,3 c)
//                csr_src_zero       - rs1/zimm is zero (set/clear no-write)
//                exc_request/cause  - synchronous exception from decoder
//                exc_ret            - mret
//                timer_irq          - machine timer interrupt level
//                csr_rdata          - pre-write value of addressed CSR
//                trap_taken         - trap entered this cycle
//                exc_ret_taken      - mret executed this cycle
//                redirect_pc        - mtvec base / mepc / 0
//                illegal_csr        - CSR access illegal this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_trap_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_src_zero,
  input  logic        exc_request,
  input  logic [31:0] exc_cause,
  input  logic        exc_ret,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        trap_taken,
  output logic        exc_ret_taken,
  output logic [31:0] redirect_pc,
  output logic        illegal_csr
);

  localparam logic [1:0]  OP_NONE  = 2'd0;
  localparam logic [1:0]  OP_WRITE = 2'd1;
  localparam logic [1:0]  OP_SET   = 2'd2;
  localparam logic [1:0]  OP_CLEAR = 2'd3;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [31:0] ALIGN4_MASK   = 32'hFFFF_FFFC;

  // Architectural state
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_mtie;
  logic [31:0] mtvec;     // low two bits always stored as zero
  logic [31:0] mscratch;
  logic [31:0] mepc;      // low two bits always stored as zero
  logic [31:0] mcause;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  // Decode / datapath
  logic [31:0] read_val;
  logic        addr_mapped;
  logic        addr_ro;
  logic        write_effective;
  logic [31:0] write_val;
  logic        active;
  logic        irq_take;
  logic        wr_en;
  logic        retire;
  logic [63:0] mcycle_nxt;
  logic [63:0] minstret_nxt;

  // Read mux; also classifies the address as mapped and/or read-only.
  always_comb begin
    read_val    = 32'h0;
    addr_mapped = 1'b1;
    addr_ro     = 1'b0;
    case (csr_addr)
      A_MSTATUS:   read_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      A_MISA:      read_val = MISA_VALUE;
      A_MIE:       read_val = {24'b0, mie_mtie, 7'b0};
      A_MTVEC:     read_val = mtvec;
      A_MSCRATCH:  read_val = mscratch;
      A_MEPC:      read_val = mepc;
      A_MCAUSE:    read_val = mcause;
      A_MIP:       read_val = {24'b0, timer_irq, 7'b0};
      A_MCYCLE:    read_val = mcycle[31:0];
      A_MCYCLEH:   read_val = mcycle[63:32];
      A_MINSTRET:  read_val = minstret[31:0];
      A_MINSTRETH: read_val = minstret[63:32];
      A_CYCLE: begin
        read_val = mcycle[31:0];
        addr_ro  = 1'b1;
      end
      A_CYCLEH: begin
        read_val = mcycle[63:32];
        addr_ro  = 1'b1;
      end
      A_INSTRET: begin
        read_val = minstret[31:0];
        addr_ro  = 1'b1;
      end
      A_INSTRETH: begin
        read_val = minstret[63:32];
        addr_ro  = 1'b1;
      end
      A_MVENDORID, A_MARCHID, A_MIMPID, A_MHARTID: begin
        read_val = 32'h0;
        addr_ro  = 1'b1;
      end
      default: addr_mapped = 1'b0;
    endcase
  end

  // Read-modify-write value and effective-write qualification. Set/clear
  // with a zero source are pure reads and may legally target read-only CSRs.
  always_comb begin
    write_val       = csr_wdata;
    write_effective = 1'b0;
    case (csr_op)
      OP_WRITE: begin
        write_val       = csr_wdata;
        write_effective = 1'b1;
      end
      OP_SET: begin
        write_val       = read_val | csr_wdata;
        write_effective = ~csr_src_zero;
      end
      OP_CLEAR: begin
        write_val       = read_val & ~csr_wdata;
        write_effective = ~csr_src_zero;
      end
      default: begin
        write_val       = csr_wdata;
        write_effective = 1'b0;
      end
    endcase
  end

  // Event arbitration: interrupt > exception > illegal CSR > mret > write.
  always_comb begin
    active        = instr_valid & ~rst;
    illegal_csr   = active & (csr_op != OP_NONE) & (~addr_mapped | (addr_ro & write_effective));
    irq_take      = active & mstatus_mie & mie_mtie & timer_irq;
    trap_taken    = irq_take | (active & exc_request) | illegal_csr;
    exc_ret_taken = active & ~trap_taken & exc_ret;
    wr_en         = active & ~trap_taken & ~exc_ret & write_effective;
    retire        = active & ~trap_taken;

    if (trap_taken)         redirect_pc = mtvec & ALIGN4_MASK;
    else if (exc_ret_taken) redirect_pc = mepc;
    else                    redirect_pc = 32'h0;

    csr_rdata = read_val;
  end

  // Counters: a write to one half replaces it, holds the other half and
  // suppresses that counter's increment for the cycle.
  always_comb begin
    mcycle_nxt   = mcycle + 64'd1;
    minstret_nxt = minstret + {63'b0, retire};
    if (wr_en) begin
      case (csr_addr)
        A_MCYCLE:    mcycle_nxt   = {mcycle[63:32], write_val};
        A_MCYCLEH:   mcycle_nxt   = {write_val, mcycle[31:0]};
        A_MINSTRET:  minstret_nxt = {minstret[63:32], write_val};
        A_MINSTRETH: minstret_nxt = {write_val, minstret[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mtvec        <= RESET_MTVEC & ALIGN4_MASK;
      mscratch     <= 32'h0;
      mepc         <= 32'h0;
      mcause       <= 32'h0;
      mcycle       <= 64'h0;
      minstret     <= 64'h0;
    end else begin
      mcycle   <= mcycle_nxt;
      minstret <= minstret_nxt;
      if (trap_taken) begin
        mepc         <= pc & ALIGN4_MASK;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        if (irq_take)         mcause <= CAUSE_MTI;
        else if (exc_request) mcause <= exc_cause;
        else                  mcause <= CAUSE_ILLEGAL;
      end else if (exc_ret_taken) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_en) begin
        case (csr_addr)
          A_MSTATUS: begin
            mstatus_mie  <= write_val[3];
            mstatus_mpie <= write_val[7];
          end
          A_MIE:      mie_mtie <= write_val[7];
          A_MTVEC:    mtvec    <= write_val & ALIGN4_MASK;
          A_MSCRATCH: mscratch <= write_val;
          A_MEPC:     mepc     <= write_val & ALIGN4_MASK;
          A_MCAUSE:   mcause   <= write_val;
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_csr_trap_unit
//  Description : Directed self-checking bench for csr_trap_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_trap_unit;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] pc;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_src_zero;
  logic        exc_request;
  logic [31:0] exc_cause;
  logic        exc_ret;
  logic        timer_irq;
  logic [31:0] csr_rdata;
  logic        trap_taken;
  logic        exc_ret_taken;
  logic [31:0] redirect_pc;
  logic        illegal_csr;

  int checks;
  int errors;
  int retired;

  csr_trap_unit #(
    .RESET_MTVEC(32'h0000_0080),
    .MISA_VALUE (32'h4000_0100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .csr_op       (csr_op),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_src_zero (csr_src_zero),
    .exc_request  (exc_request),
    .exc_cause    (exc_cause),
    .exc_ret      (exc_ret),
    .timer_irq    (timer_irq),
    .csr_rdata    (csr_rdata),
    .trap_taken   (trap_taken),
    .exc_ret_taken(exc_ret_taken),
    .redirect_pc  (redirect_pc),
    .illegal_csr  (illegal_csr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic idle();
    instr_valid  = 1'b0;
    pc           = 32'h0;
    csr_op       = 2'd0;
    csr_addr     = 12'h0;
    csr_wdata    = 32'h0;
    csr_src_zero = 1'b0;
    exc_request  = 1'b0;
    exc_cause    = 32'h0;
    exc_ret      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Present one completing instruction with a CSR access (pc set separately).
  task automatic exec(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic sz);
    instr_valid  = 1'b1;
    csr_op       = op;
    csr_addr     = a;
    csr_wdata    = wd;
    csr_src_zero = sz;
    #0.5;
  endtask

  // Non-intrusive read: no valid instruction, just the combinational read port.
  task automatic peek(input logic [11:0] a, output logic [31:0] d);
    instr_valid = 1'b0;
    csr_op      = 2'd0;
    csr_addr    = a;
    #0.5;
    d = csr_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    idle();
    timer_irq   = 1'b0;
    rst         = 1'b1;
    instr_valid = 1'b1;
    exc_request = 1'b1;
    exc_ret     = 1'b1;
    csr_op      = 2'd1;
    csr_addr    = 12'h7FF;
    #0.5;
    checks++; if (trap_taken !== 1'b0) begin errors++; $display("FAIL rst_trap got %b exp 0", trap_taken); end
    checks++; if (illegal_csr !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", illegal_csr); end
    checks++; if (exc_ret_taken !== 1'b0) begin errors++; $display("FAIL rst_ret got %b exp 0", exc_ret_taken); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect got %h exp 0", redirect_pc); end
    step();
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    peek(12'hB00, d);
    checks++; if (d !== 32'd10) begin errors++; $display("FAIL mcycle_10 got %h exp %h", d, 32'd10); end
    peek(12'h300, d);
    checks++; if (d !== 32'h0000_1800) begin errors++; $display("FAIL rst_mstatus got %h exp 00001800", d); end
    peek(12'h305, d);
    checks++; if (d !== 32'h0000_0080) begin errors++; $display("FAIL rst_mtvec got %h exp 00000080", d); end
    peek(12'h301, d);
    checks++; if (d !== 32'h4000_0100) begin errors++; $display("FAIL misa got %h exp 40000100", d); end
    peek(12'hB02, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_minstret got %h exp 0", d); end
    retired = 0;
  endtask

  task automatic test_rw();
    logic [31:0] d;
    exec(2'd1, 12'h340, 32'hDEAD_BEEF, 1'b0);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rw_old got %h exp 0", csr_rdata); end
    checks++; if (illegal_csr !== 1'b0) begin errors++; $display("FAIL rw_illegal got %b exp 0", illegal_csr); end
    step(); retired++;
    exec(2'd2, 12'h340, 32'h0, 1'b1);
    checks++; if (csr_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rs_read got %h exp deadbeef", csr_rdata); end
    step(); retired++;
    peek(12'h340, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rs_nowrite got %h exp deadbeef", d); end
    exec(2'd3, 12'h340, 32'h0000_00FF, 1'b0);
    step(); retired++;
    peek(12'h340, d);
    checks++; if (d !== 32'hDEAD_BE00) begin errors++; $display("FAIL rc_value got %h exp deadbe00", d); end
    peek(12'hC02, d);
    checks++; if (d !== retired) begin errors++; $display("FAIL rw_instret got %h exp %h", d, retired); end
  endtask

  task automatic test_trap();
    logic [31:0] d;
    exec(2'd1, 12'h305, 32'h0000_0103, 1'b0);
    step(); retired++;
    peek(12'h305, d);
    checks++; if (d !== 32'h0000_0100) begin errors++; $display("FAIL mtvec_align got %h exp 00000100", d); end
    exec(2'd1, 12'h300, 32'h0000_0008, 1'b0);
    step(); retired++;
    peek(12'h300, d);
    checks++; if (d !== 32'h0000_1808) begin errors++; $display("FAIL mstatus_mie got %h exp 00001808", d); end
    pc          = 32'h40;
    exc_request = 1'b1;
    exc_cause   = 32'd11;
    exec(2'd0, 12'h0, 32'h0, 1'b0);
    checks++; if (trap_taken !== 1'b1) begin errors++; $display("FAIL exc_trap got %b exp 1", trap_taken); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL exc_redirect got %h exp 00000100", redirect_pc); end
    checks++; if (exc_ret_taken !== 1'b0) begin errors++; $display("FAIL exc_ret_flag got %b exp 0", exc_ret_taken); end
    step();
    peek(12'h341, d);
    checks++; if (d !== 32'h40) begin errors++; $display("FAIL exc_mepc got %h exp 00000040", d); end
    peek(12'h342, d);
    checks++; if (d !== 32'd11) begin errors++; $display("FAIL exc_mcause got %h exp 0000000b", d); end
    peek(12'h300, d);
    checks++; if (d !== 32'h0000_1880) begin errors++; $display("FAIL exc_mstatus got %h exp 00001880", d); end
    exc_ret = 1'b1;
    exec(2'd0, 12'h0, 32'h0, 1'b0);
    checks++; if (exc_ret_taken !== 1'b1) begin errors++; $display("FAIL mret_flag got %b exp 1", exc_ret_taken); end
    checks++; if (redirect_pc !== 32'h40) begin errors++; $display("FAIL mret_redirect got %h exp 00000040", redirect_pc); end
    checks++; if (trap_taken !== 1'b0) begin errors++; $display("FAIL mret_trap got %b exp 0", trap_taken); end
    step(); retired++;
    peek(12'h300, d);
    checks++; if (d !== 32'h0000_1888) begin errors++; $display("FAIL mret_mstatus got %h exp 00001888", d); end
    peek(12'hB02, d);
    checks++; if (d !== retired) begin errors++; $display("FAIL trap_instret got %h exp %h", d, retired); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    exec(2'd1, 12'h304, 32'h0000_0080, 1'b0);
    step(); retired++;
    timer_irq = 1'b1;
    peek(12'h344, d);
    checks++; if (d !== 32'h80) begin errors++; $display("FAIL mip_read got %h exp 00000080", d); end
    pc = 32'h80;
    exec(2'd1, 12'h340, 32'h1234_5678, 1'b0);
    checks++; if (trap_taken !== 1'b1) begin errors++; $display("FAIL irq_trap got %b exp 1", trap_taken); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL irq_redirect got %h exp 00000100", redirect_pc); end
    step();
    peek(12'h342, d);
    checks++; if (d !== 32'h8000_0007) begin errors++; $display("FAIL irq_mcause got %h exp 80000007", d); end
    peek(12'h340, d);
    checks++; if (d !== 32'hDEAD_BE00) begin errors++; $display("FAIL irq_mscratch got %h exp deadbe00", d); end
    peek(12'h341, d);
    checks++; if (d !== 32'h80) begin errors++; $display("FAIL irq_mepc got %h exp 00000080", d); end
    peek(12'hB02, d);
    checks++; if (d !== retired) begin errors++; $display("FAIL irq_instret got %h exp %h", d, retired); end
    peek(12'h300, d);
    checks++; if (d !== 32'h0000_1880) begin errors++; $display("FAIL irq_mstatus got %h exp 00001880", d); end
    // MIE is now 0, so the same access must commit.
    pc = 32'h80;
    exec(2'd1, 12'h340, 32'h1234_5678, 1'b0);
    checks++; if (trap_taken !== 1'b0) begin errors++; $display("FAIL masked_trap got %b exp 0", trap_taken); end
    step(); retired++;
    peek(12'h340, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL masked_write got %h exp 12345678", d); end
    timer_irq = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    exec(2'd1, 12'hC00, 32'h5, 1'b0);
    checks++; if (illegal_csr !== 1'b1) begin errors++; $display("FAIL ro_illegal got %b exp 1", illegal_csr); end
    checks++; if (trap_taken !== 1'b1) begin errors++; $display("FAIL ro_trap got %b exp 1", trap_taken); end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL ro_redirect got %h exp 00000100", redirect_pc); end
    step();
    peek(12'h342, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ro_mcause got %h exp 00000002", d); end
    exec(2'd0, 12'h342, 32'h0, 1'b0);
    exec(2'd1, 12'h342, 32'h55, 1'b0);
    step(); retired++;
    exec(2'd1, 12'h7FF, 32'h0, 1'b0);
    checks++; if (illegal_csr !== 1'b1) begin errors++; $display("FAIL unmapped_illegal got %b exp 1", illegal_csr); end
    step();
    peek(12'h342, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL unmapped_mcause got %h exp 00000002", d); end
    exec(2'd1, 12'hB00, 32'h0000_1000, 1'b0);
    step(); retired++;
    exec(2'd2, 12'hC00, 32'h0, 1'b1);
    checks++; if (illegal_csr !== 1'b0) begin errors++; $display("FAIL ro_read_illegal got %b exp 0", illegal_csr); end
    checks++; if (csr_rdata !== 32'h1000) begin errors++; $display("FAIL ro_read_data got %h exp 00001000", csr_rdata); end
    step(); retired++;
    peek(12'hB02, d);
    checks++; if (d !== retired) begin errors++; $display("FAIL ill_instret got %h exp %h", d, retired); end
  endtask

  task automatic test_counter();
    logic [31:0] d;
    exec(2'd1, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    step();
    exec(2'd1, 12'hB80, 32'h0, 1'b0);
    step();
    peek(12'hB00, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cyc_lo_held got %h exp ffffffff", d); end
    peek(12'hB80, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL cyc_hi_write got %h exp 0", d); end
    @(posedge clk);
    #1;
    peek(12'hC80, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL cyc_carry_hi got %h exp 1", d); end
    peek(12'hB00, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL cyc_carry_lo got %h exp 0", d); end
    exec(2'd1, 12'hB02, 32'hFFFF_FFFF, 1'b0);
    step();
    exec(2'd1, 12'hB82, 32'hFFFF_FFFF, 1'b0);
    step();
    peek(12'hB02, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ins_lo_held got %h exp ffffffff", d); end
    exec(2'd0, 12'h0, 32'h0, 1'b0);
    step();
    peek(12'hB02, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ins_wrap_lo got %h exp 0", d); end
    peek(12'hB82, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ins_wrap_hi got %h exp 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    exec(2'd1, 12'h340, 32'hAAAA_AAAA, 1'b0);
    step();
    rst         = 1'b1;
    pc          = 32'h200;
    exc_request = 1'b1;
    exc_cause   = 32'd3;
    exec(2'd1, 12'h340, 32'h5555_5555, 1'b0);
    checks++; if (trap_taken !== 1'b0) begin errors++; $display("FAIL midrst_trap got %b exp 0", trap_taken); end
    step();
    rst = 1'b0;
    peek(12'h300, d);
    checks++; if (d !== 32'h0000_1800) begin errors++; $display("FAIL midrst_mstatus got %h exp 00001800", d); end
    peek(12'h305, d);
    checks++; if (d !== 32'h0000_0080) begin errors++; $display("FAIL midrst_mtvec got %h exp 00000080", d); end
    peek(12'h340, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_mscratch got %h exp 0", d); end
    peek(12'h341, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_mepc got %h exp 0", d); end
    peek(12'h342, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_mcause got %h exp 0", d); end
    peek(12'h304, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_mie got %h exp 0", d); end
    peek(12'hB00, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_mcycle got %h exp 0", d); end
    peek(12'hB80, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_mcycleh got %h exp 0", d); end
    peek(12'hB02, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_minstret got %h exp 0", d); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    retired = 0;
    rst     = 1'b1;
    timer_irq = 1'b0;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_rw();
    test_trap();
    test_irq();
    test_illegal();
    test_counter();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
